// File: rtl/partial_eval_sequencer.sv
// rtl/partial_eval_sequencer.sv - one-shot preload/settle/sample sequencer for an extracted partial circuit
// Optional build macro PEVAL_CHECK_EN adds cmd_expect/rsp_mismatch comparison of the sampled output.
module partial_eval_sequencer #(
  parameter int W_I    = 2,
  parameter int W_R    = 2,
  parameter int N_LIFT = 4,
  parameter int W_O    = 4,
  parameter int CNT_W  = 4
) (
  input  logic              CLK,
  input  logic              ASYNCRESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [W_I-1:0]    cmd_i0,
  input  logic [N_LIFT-1:0] cmd_lifted,
  input  logic [W_R-1:0]    cmd_pre0,
  input  logic [W_R-1:0]    cmd_pre1,
  input  logic [CNT_W-1:0]  cmd_cycles,
  output logic [W_I-1:0]    dut_i0,
  output logic [N_LIFT-1:0] dut_lifted,
  output logic [W_R-1:0]    dut_reg0_in,
  output logic [W_R-1:0]    dut_reg1_in,
  input  logic [W_R-1:0]    dut_reg0_out,
  input  logic [W_R-1:0]    dut_reg1_out,
  input  logic [W_O-1:0]    dut_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W_O-1:0]    rsp_o,
  output logic              busy
`ifdef PEVAL_CHECK_EN
  ,
  input  logic [W_O-1:0]    cmd_expect,
  output logic              rsp_mismatch
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_RUN,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t             state, state_nxt;
  logic [W_I-1:0]     i0_q;
  logic [N_LIFT-1:0]  lift_q;
  logic [W_R-1:0]     pre0_q, pre1_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [W_O-1:0]     rsp_o_q;
  logic               accept;

  assign accept     = cmd_valid & cmd_ready;
  assign dut_i0     = i0_q;
  assign dut_lifted = lift_q;
  assign rsp_o      = rsp_o_q;

`ifdef PEVAL_CHECK_EN
  logic [W_O-1:0] exp_q;
  logic           mis_q;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      exp_q <= '0;
      mis_q <= 1'b0;
    end else begin
      if (accept) exp_q <= cmd_expect;
      if (state == S_CAPTURE) mis_q <= (dut_o != exp_q);
    end
  end

  assign rsp_mismatch = mis_q;
`endif

  // The settle count is loaded at accept; PRELOAD leaves it untouched so RUN sees cmd_cycles.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state   <= S_IDLE;
      i0_q    <= '0;
      lift_q  <= '0;
      pre0_q  <= '0;
      pre1_q  <= '0;
      cnt_q   <= '0;
      rsp_o_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        i0_q   <= cmd_i0;
        lift_q <= cmd_lifted;
        pre0_q <= cmd_pre0;
        pre1_q <= cmd_pre1;
        cnt_q  <= cmd_cycles;
      end
      if (state == S_RUN) cnt_q <= cnt_q - 1'b1;
      if (state == S_CAPTURE) rsp_o_q <= dut_o;
    end
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    dut_reg0_in = dut_reg0_out;
    dut_reg1_in = dut_reg1_out;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = S_PRELOAD;
      end
      S_PRELOAD: begin
        dut_reg0_in = pre0_q;
        dut_reg1_in = pre1_q;
        state_nxt   = (cnt_q != '0) ? S_RUN : S_CAPTURE;
      end
      S_RUN: begin
        dut_reg0_in = pre0_q;
        dut_reg1_in = pre1_q;
        if (cnt_q == CNT_W'(1)) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        dut_reg0_in = pre0_q;
        dut_reg1_in = pre1_q;
        state_nxt   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_partial_eval_sequencer.sv
// tb/tb_partial_eval_sequencer.sv - randomized self-checking bench with a partial-circuit model
module tb_partial_eval_sequencer;

  logic       CLK = 1'b0;
  logic       ASYNCRESETN;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_i0;
  logic [3:0] cmd_lifted;
  logic [1:0] cmd_pre0, cmd_pre1;
  logic [3:0] cmd_cycles;
  logic [1:0] dut_i0;
  logic [3:0] dut_lifted;
  logic [1:0] dut_reg0_in, dut_reg1_in;
  logic [1:0] dut_reg0_out, dut_reg1_out;
  logic [3:0] dut_o;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_o;
  logic       busy;
`ifdef PEVAL_CHECK_EN
  logic [3:0] cmd_expect;
  logic       rsp_mismatch;
  logic       exp_mis_m;
`endif

  int checks = 0;
  int errors = 0;

  partial_eval_sequencer u_dut (
    .CLK          (CLK),
    .ASYNCRESETN  (ASYNCRESETN),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_i0       (cmd_i0),
    .cmd_lifted   (cmd_lifted),
    .cmd_pre0     (cmd_pre0),
    .cmd_pre1     (cmd_pre1),
    .cmd_cycles   (cmd_cycles),
    .dut_i0       (dut_i0),
    .dut_lifted   (dut_lifted),
    .dut_reg0_in  (dut_reg0_in),
    .dut_reg1_in  (dut_reg1_in),
    .dut_reg0_out (dut_reg0_out),
    .dut_reg1_out (dut_reg1_out),
    .dut_o        (dut_o),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_o        (rsp_o),
    .busy         (busy)
`ifdef PEVAL_CHECK_EN
    ,
    .cmd_expect   (cmd_expect),
    .rsp_mismatch (rsp_mismatch)
`endif
  );

  always #5 CLK = ~CLK;

  // Partial circuit: two externally loaded registers plus combinational O.
  logic [1:0] c_reg0, c_reg1;
  always @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      c_reg0 <= 2'b00;
      c_reg1 <= 2'b00;
    end else begin
      c_reg0 <= dut_reg0_in;
      c_reg1 <= dut_reg1_in;
    end
  end
  assign dut_reg0_out = c_reg0;
  assign dut_reg1_out = c_reg1;
  assign dut_o = {dut_lifted[1], dut_lifted[0], ~dut_i0[0], c_reg0[0] | c_reg1[0]};

  function automatic logic [3:0] ref_o(input logic [1:0] i0, input logic [3:0] lift,
                                       input logic [1:0] p0, input logic [1:0] p1);
    return {lift[1], lift[0], ~i0[0], p0[0] | p1[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input logic [1:0] i0, input logic [3:0] lift, input logic [1:0] p0,
                      input logic [1:0] p1, input logic [3:0] cyc, output int waited);
    logic acc;
    cmd_i0 = i0; cmd_lifted = lift; cmd_pre0 = p0; cmd_pre1 = p1; cmd_cycles = cyc;
    cmd_valid = 1'b1;
    waited = 0;
    acc = 1'b0;
    while (!acc) begin
      acc = cmd_ready;
      @(posedge CLK); #1;
      waited++;
      if (!acc && waited > 50) begin
        chk("accept_timeout", 32'(waited), 32'd0);
        acc = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    cmd_i0 = 2'($urandom); cmd_lifted = 4'($urandom);
    cmd_pre0 = 2'($urandom); cmd_pre1 = 2'($urandom); cmd_cycles = 4'($urandom);
  endtask

  task automatic wait_rsp(input int cyc, input logic [3:0] exp_o);
    int n;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!rsp_valid && n < 40);
    chk("latency", 32'(n), 32'(cyc + 2));
    chk("rsp_o", 32'(rsp_o), 32'(exp_o));
`ifdef PEVAL_CHECK_EN
    chk("rsp_mismatch", 32'(rsp_mismatch), 32'(exp_mis_m));
`endif
  endtask

  task automatic finish_rsp(input int hold, input logic keep, input logic [3:0] exp_o);
    for (int k = 0; k < hold; k++) begin
      @(posedge CLK); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_o", 32'(rsp_o), 32'(exp_o));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    if (!keep) cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_hold(input logic [1:0] p0, input logic [1:0] p1);
    repeat (3) @(posedge CLK);
    #1;
    chk("idle_reg0", 32'(c_reg0), 32'(p0));
    chk("idle_reg1", 32'(c_reg1), 32'(p1));
  endtask

  initial begin
    int w;
    logic [1:0] i0, p0, p1;
    logic [3:0] lift, cyc, eo;
    ASYNCRESETN = 1'b0;
    cmd_valid = 1'b0; cmd_i0 = '0; cmd_lifted = '0; cmd_pre0 = '0; cmd_pre1 = '0;
    cmd_cycles = '0; rsp_ready = 1'b0;
`ifdef PEVAL_CHECK_EN
    cmd_expect = '0; exp_mis_m = 1'b0;
`endif
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_o", 32'(rsp_o), 32'd0);
    chk("rst_dut_i0", 32'(dut_i0), 32'd0);
    chk("rst_dut_lifted", 32'(dut_lifted), 32'd0);
`ifdef PEVAL_CHECK_EN
    chk("rst_mismatch", 32'(rsp_mismatch), 32'd0);
`endif
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;

    // Basic vector
`ifdef PEVAL_CHECK_EN
    cmd_expect = 4'b1110; exp_mis_m = 1'b1;
`endif
    send(2'b10, 4'b0011, 2'b01, 2'b00, 4'd3, w);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("basic_dut_i0", 32'(dut_i0), 32'b10);
    chk("basic_dut_lifted", 32'(dut_lifted), 32'b0011);
    wait_rsp(3, 4'b1111);
    finish_rsp(0, 1'b0, 4'b1111);

    // Zero settle count
`ifdef PEVAL_CHECK_EN
    cmd_expect = 4'b0000; exp_mis_m = 1'b0;
`endif
    send(2'b01, 4'b0000, 2'b00, 2'b00, 4'd0, w);
    wait_rsp(0, 4'b0000);
    finish_rsp(0, 1'b0, 4'b0000);

    // Backpressure with a competing command presented during RESP
`ifdef PEVAL_CHECK_EN
    cmd_expect = 4'b1111; exp_mis_m = 1'b0;
`endif
    send(2'b10, 4'b0011, 2'b01, 2'b00, 4'd3, w);
    wait_rsp(3, 4'b1111);
    cmd_valid = 1'b1;
    finish_rsp(6, 1'b0, 4'b1111);

    // Back-to-back: second command already valid at the response handshake
    send(2'b11, 4'b1010, 2'b10, 2'b11, 4'd2, w);
    eo = ref_o(2'b11, 4'b1010, 2'b10, 2'b11);
`ifdef PEVAL_CHECK_EN
    exp_mis_m = (cmd_expect != eo);
`endif
    wait_rsp(2, eo);
    cmd_i0 = 2'b00; cmd_lifted = 4'b0110; cmd_pre0 = 2'b11; cmd_pre1 = 2'b00; cmd_cycles = 4'd1;
    cmd_valid = 1'b1;
    finish_rsp(2, 1'b1, eo);
    send(2'b00, 4'b0110, 2'b11, 2'b00, 4'd1, w);
    chk("b2b_wait", 32'(w), 32'd1);
    chk("b2b_busy", 32'(busy), 32'd1);
    eo = ref_o(2'b00, 4'b0110, 2'b11, 2'b00);
`ifdef PEVAL_CHECK_EN
    exp_mis_m = (cmd_expect != eo);
`endif
    wait_rsp(1, eo);
    finish_rsp(1, 1'b0, eo);
    check_hold(2'b11, 2'b00);

    // Asynchronous reset in the middle of RUN
    send(2'b10, 4'b1111, 2'b01, 2'b01, 4'd10, w);
    repeat (4) @(posedge CLK);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp_o", 32'(rsp_o), 32'd0);
    chk("mid_rst_dut_i0", 32'(dut_i0), 32'd0);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;

    // Randomized commands against the reference
    for (int it = 0; it < 24; it++) begin
      i0 = 2'($urandom); lift = 4'($urandom);
      p0 = 2'($urandom); p1 = 2'($urandom);
      cyc = (it == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      eo = ref_o(i0, lift, p0, p1);
`ifdef PEVAL_CHECK_EN
      cmd_expect = ($urandom_range(0, 1) == 1) ? eo : 4'($urandom);
      exp_mis_m = (cmd_expect != eo);
`endif
      send(i0, lift, p0, p1, cyc, w);
      chk("rnd_dut_i0", 32'(dut_i0), 32'(i0));
      wait_rsp(int'(cyc), eo);
      finish_rsp($urandom_range(0, 3), 1'b0, eo);
      if (it % 4 == 0) check_hold(p0, p1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
